dflipflop_register_universal: RTL
=================================

Name: dflipflop_register_universal

Overview:
- Parametrised successor to the single master-slave D flip-flop: a WIDTH-bit edge-triggered register bank built from the same D-FF primitive.
- Adds a clock enable, synchronous reset to a parameter value, parallel load, shift and rotate in both directions, up/down counting, serial outputs, terminal-count and a sticky overflow flag.
- Used as the generic storage/sequencing element in generated example circuits: registers, shift registers and counters.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32.
- RESET_VALUE, 0, value loaded into q on reset; truncated to WIDTH bits.

Ports:
- input_clock1_clk_1  input  1  clock; all state updates on the rising edge.
- input_push_button2_rst_2  input  1  synchronous active-high reset.
- input_en  input  1  clock enable; 0 = hold all state.
- input_mode  input  3  operation select (encoding in Behaviour).
- input_d  input  WIDTH  parallel load data.
- input_sil  input  1  serial input for shift-left; enters at bit 0.
- input_sir  input  1  serial input for shift-right; enters at bit WIDTH-1.
- output_q  output  WIDTH  register contents.
- output_q_n  output  WIDTH  bitwise complement of output_q.
- output_sol  output  1  output_q[WIDTH-1]; combinational from q.
- output_sor  output  1  output_q[0]; combinational from q.
- output_tc  output  1  terminal count; combinational.
- output_ovf  output  1  sticky overflow/underflow flag; registered.

Behaviour:
- Clocking:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - No asynchronous paths into state.
- Priority at each rising edge: reset > en=0 > mode.
- Reset:
  - q <= RESET_VALUE; ovf <= 0.
  - Therefore q_n = ~RESET_VALUE, and sol/sor/tc follow from q.
  - Reset asserted mid-operation in any mode wins on that edge; the pending operation is discarded.
- en=0: q and ovf hold regardless of mode, d or serial inputs.
- Mode encoding (en=1), applied with latency 1; the new q is visible after the edge:
  - 000 hold: q unchanged.
  - 001 load: q <= d; ovf <= 0.
  - 010 shift left: q <= {q[WIDTH-2:0], sil}.
  - 011 shift right: q <= {sir, q[WIDTH-1:1]}.
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 110 count up: q <= q+1 modulo 2^WIDTH.
  - 111 count down: q <= q-1 modulo 2^WIDTH.
- Wrap-around:
  - Count up from all-ones gives 0 and sets ovf <= 1.
  - Count down from 0 gives all-ones and sets ovf <= 1.
- ovf:
  - Sticky: it stays 1 through later hold/shift/rotate/count operations.
  - Cleared only by reset or by load.
  - A wrap on the same edge as a load cannot occur, since the modes are exclusive.
- tc = en & ((mode==110 & q==all-ones) | (mode==111 & q==0)); otherwise 0.
  - tc is high in the cycle before the wrapping edge, for cascading a next stage's en.
- Serial outputs:
  - sol/sor reflect the current q, i.e. the bit that leaves on the next shift.
  - No extra register stage.
- Unknown inputs: mode is fully decoded, so there is no illegal state.
- Outputs carry no X after the first reset edge.

Test Plan:
- Reset: WIDTH=4, RESET_VALUE=4'hA; assert rst 1 cycle -> q=1010, q_n=0101, sol=1, sor=0, ovf=0, tc=0.
- Load and enable: mode=001, d=0110, en=1 -> q=0110 after 1 edge. Then en=0, mode=110 for 3 edges -> q stays 0110.
- Shift and rotate:
  - From q=1001: shift left with sil=0 -> 0010; shift right with sir=1 -> 1001.
  - From q=1001: rotate left -> 0011; rotate right -> 1001.
  - sol/sor track q combinationally in each cycle.
- Count-up wrap:
  - Load 1110, count up -> q=1111 with tc=1.
  - Next edge -> q=0000, ovf=1, tc=0.
  - Further counting keeps ovf=1.
  - Load 0000 -> ovf=0.
- Count-down wrap with reset mid-run:
  - Load 0001, count down -> 0000 (tc=1), then 1111 with ovf=1.
  - Assert rst on the following edge while mode=111 -> q=RESET_VALUE, ovf=0.
- Width sweep: WIDTH=2 and WIDTH=8.
  - WIDTH=8: count up 256 edges from 0 -> q back to 0, ovf=1, tc high exactly once.
  - WIDTH=2: rotate left 2 edges returns to the start value.

Source files
------------

// File: rtl/dflipflop_register_universal.sv
// WIDTH-bit universal register: clock enable, synchronous reset to a parameter value,
// parallel load, shift/rotate both ways, up/down count with terminal count and sticky overflow.
module dflipflop_register_universal #(
    parameter int          WIDTH       = 4,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             input_clock1_clk_1,
    input  logic             input_push_button2_rst_2,
    input  logic             input_en,
    input  logic [2:0]       input_mode,
    input  logic [WIDTH-1:0] input_d,
    input  logic             input_sil,
    input  logic             input_sir,
    output logic [WIDTH-1:0] output_q,
    output logic [WIDTH-1:0] output_q_n,
    output logic             output_sol,
    output logic             output_sor,
    output logic             output_tc,
    output logic             output_ovf
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_UP    = 3'b110,
        MODE_DOWN  = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    mode_e            mode;

    assign mode = mode_e'(input_mode);

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (input_en) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: begin
                    q_d   = input_d;
                    ovf_d = 1'b0;
                end
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], input_sil};
                MODE_SHR:  q_d = {input_sir, q_q[WIDTH-1:1]};
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_UP: begin
                    q_d = q_q + ONE;
                    if (q_q == ONES) ovf_d = 1'b1;
                end
                MODE_DOWN: begin
                    q_d = q_q - ONE;
                    if (q_q == ZERO) ovf_d = 1'b1;
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Reset outranks the enable so a stalled stage can still be initialised.
    always_ff @(posedge input_clock1_clk_1) begin
        if (input_push_button2_rst_2) begin
            q_q   <= RST_Q;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            assign output_q[gi]   = q_q[gi];
            assign output_q_n[gi] = ~q_q[gi];
        end
    endgenerate

    assign output_sol = q_q[WIDTH-1];
    assign output_sor = q_q[0];
    assign output_ovf = ovf_q;
    // Terminal count looks ahead one edge so it can drive the next stage's enable.
    assign output_tc  = input_en & (((mode == MODE_UP)   && (q_q == ONES)) ||
                                    ((mode == MODE_DOWN) && (q_q == ZERO)));

endmodule
